microseq: RTL and testbench

MICROSEQ -- requirements
Module: microseq

---
 rtl/microseq_pkg.sv | 37 +++
 rtl/microseq_dispatch.sv | 24 ++
 rtl/microseq.sv | 173 +++++++++++++++++
 tb/tb_microseq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/microseq_pkg.sv
// microseq_pkg: shared types and constants for the microcode sequencer.
//   - seq_state_e : sequencer FSM states
//   - cond_e      : encodings of the 2-bit ROM condition field
//   - default highest microaddress and halt opcode
//   - opcode -> microaddress dispatch table
package microseq_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StWait   = 2'd2,
        StHalted = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        CondAlways  = 2'd0,  // unconditional jump
        CondZero    = 2'd1,  // jump if ALU zero flag set
        CondNotZero = 2'd2,  // jump if ALU zero flag clear
        CondGo      = 2'd3   // wait for external go, then jump
    } cond_e;

    localparam int unsigned UCODE_LAST_DFLT = 74;
    localparam logic [7:0]  HALT_OPC_DFLT   = 8'hFF;

    localparam int unsigned DISPATCH_N = 12;

    localparam logic [7:0] DISPATCH_OPC [DISPATCH_N] = '{
        8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
        8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C
    };

    localparam logic [6:0] DISPATCH_ADDR [DISPATCH_N] = '{
        7'd3,  7'd7,  7'd11, 7'd15, 7'd20, 7'd28,
        7'd37, 7'd41, 7'd45, 7'd48, 7'd51, 7'd63
    };

endpackage

// File: rtl/microseq_dispatch.sv
// microseq_dispatch: combinational opcode -> microaddress lookup.
//   opcode : instruction opcode to decode
//   addr   : entry microaddress for the opcode (0 when not found)
//   valid  : opcode is present in the dispatch table
module microseq_dispatch
    import microseq_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [6:0] addr,
    output logic       valid
);

    always_comb begin
        addr  = '0;
        valid = 1'b0;
        for (int i = 0; i < DISPATCH_N; i++) begin
            if (opcode == DISPATCH_OPC[i]) begin
                addr  = DISPATCH_ADDR[i];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/microseq.sv
// microseq: microcode sequencer producing the ROM microaddress each cycle.
//   clk, rstn       : clock, asynchronous active-low reset
//   start           : level request to begin execution at microaddress 0
//   stall           : freezes the sequencer while high
//   condition, BT,
//   jump_addr       : control fields of the current microword
//   z_flag, go      : ALU zero flag, external-event qualifier
//   ir_opcode       : current instruction opcode (dispatch source)
//   reg_out         : {9'b0, upc}, microaddress to the ROM
//   busy            : in RUN or WAIT
//   done            : one-cycle pulse on a normal halt
//   err             : illegal opcode / out-of-range address, sticky until start
module microseq
    import microseq_pkg::*;
#(
    parameter int unsigned UCODE_LAST = UCODE_LAST_DFLT,
    parameter logic [7:0]  HALT_OPC   = HALT_OPC_DFLT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        stall,
    input  logic [1:0]  condition,
    input  logic        BT,
    input  logic [6:0]  jump_addr,
    input  logic        z_flag,
    input  logic        go,
    input  logic [7:0]  ir_opcode,
    output logic [15:0] reg_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Candidate addresses are carried in 8 bits so that 127+1 stays visible as out of range.
    localparam logic [7:0] UcodeLastW = 8'(UCODE_LAST);

    seq_state_e state_q, state_d;
    logic [6:0] upc_q, upc_d;
    logic       err_q, err_d;
    logic       done_q, done_d;

    logic [6:0] disp_addr;
    logic       disp_valid;
    logic [7:0] upc_inc;
    logic [7:0] next_addr;
    logic       take;

    microseq_dispatch u_dispatch (
        .opcode (ir_opcode),
        .addr   (disp_addr),
        .valid  (disp_valid)
    );

    assign upc_inc = {1'b0, upc_q} + 8'd1;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            upc_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        err_d     = err_q;
        done_d    = 1'b0;
        next_addr = '0;
        take      = 1'b0;

        unique case (state_q)
            StIdle: begin
                upc_d = '0;
                if (start) begin
                    state_d = StRun;
                    err_d   = 1'b0;
                end
            end

            StRun: begin
                // Stall wins over every event; they are re-evaluated once it drops.
                if (!stall) begin
                    if (BT) begin
                        if (ir_opcode == HALT_OPC) begin
                            state_d = StHalted;
                            upc_d   = '0;
                            done_d  = 1'b1;
                        end else if (!disp_valid) begin
                            state_d = StHalted;
                            upc_d   = '0;
                            err_d   = 1'b1;
                        end else begin
                            next_addr = {1'b0, disp_addr};
                            take      = 1'b1;
                        end
                    end else begin
                        unique case (cond_e'(condition))
                            CondAlways: begin
                                next_addr = {1'b0, jump_addr};
                                take      = 1'b1;
                            end
                            CondZero: begin
                                next_addr = z_flag ? {1'b0, jump_addr} : upc_inc;
                                take      = 1'b1;
                            end
                            CondNotZero: begin
                                next_addr = !z_flag ? {1'b0, jump_addr} : upc_inc;
                                take      = 1'b1;
                            end
                            CondGo: begin
                                if (go) begin
                                    next_addr = {1'b0, jump_addr};
                                    take      = 1'b1;
                                end else begin
                                    state_d = StWait;
                                end
                            end
                        endcase
                    end
                end
            end

            StWait: begin
                if (go && !stall) begin
                    next_addr = {1'b0, jump_addr};
                    take      = 1'b1;
                    state_d   = StRun;
                end
            end

            StHalted: begin
                upc_d = '0;
                if (!start) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                upc_d   = '0;
            end
        endcase

        if (take) begin
            if (next_addr > UcodeLastW) begin
                state_d = StHalted;
                upc_d   = '0;
                err_d   = 1'b1;
            end else begin
                upc_d = next_addr[6:0];
            end
        end
    end

    // Outputs
    always_comb begin
        reg_out = {9'b0, upc_q};
        busy    = (state_q == StRun) || (state_q == StWait);
        done    = done_q;
        err     = err_q;
    end

endmodule

// File: tb/tb_microseq.sv
// tb_microseq: scoreboard bench for microseq. Each step drives one cycle of
// ROM fields and pushes the expected post-edge outputs; they are popped and
// compared 1 ns after the rising edge.
module tb_microseq;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        stall;
    logic [1:0]  condition;
    logic        BT;
    logic [6:0]  jump_addr;
    logic        z_flag;
    logic        go;
    logic [7:0]  ir_opcode;
    logic [15:0] reg_out;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [15:0] reg_out;
        logic        busy;
        logic        done;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    microseq dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .stall     (stall),
        .condition (condition),
        .BT        (BT),
        .jump_addr (jump_addr),
        .z_flag    (z_flag),
        .go        (go),
        .ir_opcode (ir_opcode),
        .reg_out   (reg_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive fields, push expectation, sample after the edge.
    task automatic step(input string tag, input logic st, input logic stl,
                        input logic [1:0] cnd, input logic bt, input logic [6:0] ja,
                        input logic z, input logic g, input logic [7:0] opc,
                        input logic [15:0] e_reg, input logic e_busy,
                        input logic e_done, input logic e_err);
        exp_t e;
        exp_t o;
        start     = st;
        stall     = stl;
        condition = cnd;
        BT        = bt;
        jump_addr = ja;
        z_flag    = z;
        go        = g;
        ir_opcode = opc;
        e.reg_out = e_reg;
        e.busy    = e_busy;
        e.done    = e_done;
        e.err     = e_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            o = sb.pop_front();
            check_eq({tag, "_reg_out"}, 32'(reg_out), 32'(o.reg_out));
            check_eq({tag, "_busy"},    32'(busy),    32'(o.busy));
            check_eq({tag, "_done"},    32'(done),    32'(o.done));
            check_eq({tag, "_err"},     32'(err),     32'(o.err));
        end
    endtask

    initial begin
        rstn = 1'b0;
        start = 1'b0; stall = 1'b0; condition = 2'd0; BT = 1'b0;
        jump_addr = '0; z_flag = 1'b0; go = 1'b0; ir_opcode = '0;
        #2;
        check_eq("rst_reg_out", 32'(reg_out), 32'd0);
        check_eq("rst_busy",    32'(busy),    32'd0);
        check_eq("rst_done",    32'(done),    32'd0);
        check_eq("rst_err",     32'(err),     32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        //    tag        st stl cnd bt ja  z  g  opc     reg busy done err
        step("idle",      0, 0, 0, 0, 9,  0, 0, 8'h00,  0,  0, 0, 0);
        step("start",     1, 0, 0, 0, 1,  0, 0, 8'h00,  0,  1, 0, 0);
        step("run1",      0, 0, 0, 0, 1,  0, 0, 8'h00,  1,  1, 0, 0);
        step("disp05",    0, 0, 0, 1, 0,  0, 0, 8'h05, 20,  1, 0, 0);
        step("disp0c",    0, 0, 2, 1, 9,  1, 0, 8'h0C, 63,  1, 0, 0);
        step("disp01",    0, 0, 0, 1, 0,  0, 0, 8'h01,  3,  1, 0, 0);
        step("illop",     0, 0, 0, 1, 0,  0, 0, 8'h3C,  0,  0, 0, 1);
        step("halt_idle", 0, 0, 0, 0, 0,  0, 0, 8'h00,  0,  0, 0, 1);
        step("restart",   1, 0, 0, 0, 0,  0, 0, 8'h00,  0,  1, 0, 0);

        step("to66",      0, 0, 0, 0, 66, 0, 0, 8'h00, 66,  1, 0, 0);
        step("c1_z1",     0, 0, 1, 0, 69, 1, 0, 8'h00, 69,  1, 0, 0);
        step("back66",    0, 0, 0, 0, 66, 0, 0, 8'h00, 66,  1, 0, 0);
        step("c1_z0",     0, 0, 1, 0, 69, 0, 0, 8'h00, 67,  1, 0, 0);
        step("c2_z0",     0, 0, 2, 0, 10, 0, 0, 8'h00, 10,  1, 0, 0);
        step("c2_z1",     0, 0, 2, 0, 30, 1, 0, 8'h00, 11,  1, 0, 0);
        step("to74",      0, 0, 0, 0, 74, 0, 0, 8'h00, 74,  1, 0, 0);
        step("inc75",     0, 0, 1, 0, 5,  0, 0, 8'h00,  0,  0, 0, 1);
        step("h_hold",    1, 0, 0, 0, 0,  0, 0, 8'h00,  0,  0, 0, 1);
        step("h_idle",    0, 0, 0, 0, 0,  0, 0, 8'h00,  0,  0, 0, 1);
        step("restart2",  1, 0, 0, 0, 0,  0, 0, 8'h00,  0,  1, 0, 0);
        step("jump75",    0, 0, 0, 0, 75, 0, 0, 8'h00,  0,  0, 0, 1);
        step("h_idle2",   0, 0, 0, 0, 0,  0, 0, 8'h00,  0,  0, 0, 1);
        step("restart3",  1, 0, 0, 0, 0,  0, 0, 8'h00,  0,  1, 0, 0);

        step("to5",       0, 0, 0, 0, 5,  0, 0, 8'h00,  5,  1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step("wait_go0", 0, 0, 3, 0, 12, 0, 0, 8'h00, 5, 1, 0, 0);
        end
        step("wait_go1",  0, 0, 3, 0, 12, 0, 1, 8'h00, 12,  1, 0, 0);
        step("wait2",     0, 0, 3, 0, 20, 0, 0, 8'h00, 12,  1, 0, 0);
        step("wait_stl",  0, 1, 3, 0, 20, 0, 1, 8'h00, 12,  1, 0, 0);
        step("wait_rel",  0, 0, 3, 0, 20, 0, 1, 8'h00, 20,  1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("run_stall", 0, 1, 0, 0, 40, 0, 0, 8'h00, 20, 1, 0, 0);
        end
        step("stall_rel", 0, 0, 0, 0, 40, 0, 0, 8'h00, 40,  1, 0, 0);

        step("halt_stl",  0, 1, 0, 1, 0,  0, 0, 8'hFF, 40,  1, 0, 0);
        step("halt",      0, 0, 0, 1, 0,  0, 0, 8'hFF,  0,  0, 1, 0);
        step("halt_hold", 1, 0, 0, 0, 0,  0, 0, 8'h00,  0,  0, 0, 0);
        step("halt_drop", 0, 0, 0, 0, 0,  0, 0, 8'h00,  0,  0, 0, 0);
        step("restart4",  1, 0, 0, 0, 0,  0, 0, 8'h00,  0,  1, 0, 0);

        step("to7",       0, 0, 0, 0, 7,  0, 0, 8'h00,  7,  1, 0, 0);
        step("wait7",     0, 0, 3, 0, 12, 0, 0, 8'h00,  7,  1, 0, 0);
        #3;
        rstn = 1'b0;
        #1;
        check_eq("arst_reg_out", 32'(reg_out), 32'd0);
        check_eq("arst_busy",    32'(busy),    32'd0);
        check_eq("arst_done",    32'(done),    32'd0);
        check_eq("arst_err",     32'(err),     32'd0);
        @(posedge clk);
        #1;
        check_eq("arst_hold_done", 32'(done), 32'd0);
        check_eq("arst_hold_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        step("post_rst",  0, 0, 3, 0, 12, 0, 1, 8'h00,  0,  0, 0, 0);
        step("post_start",1, 0, 0, 0, 0,  0, 0, 8'h00,  0,  1, 0, 0);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
